// File: rtl/vga_pkg.sv
// Shared geometry, record layout and capture FSM states for the glyph capture path.
package vga_pkg;

    localparam int WIDTH       = 640;
    localparam int HEIGHT      = 480;
    localparam int WIDTH_BITS  = 10;
    localparam int HEIGHT_BITS = 10;
    localparam int PIXEL_BITS  = 12;
    localparam int CHAR_W      = 8;
    localparam int CHAR_H      = 16;
    localparam int FIFO_DEPTH  = 8;

    // bits[0] is the leftmost pixel of the glyph row
    typedef struct packed {
        logic [6:0] col;
        logic [4:0] row;
        logic [3:0] line;
        logic [0:7] bits;
    } glyph_rec_t;

    localparam int REC_W = $bits(glyph_rec_t);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FRAME,
        CAPTURE,
        DRAIN
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO: o_rd_data shows the head entry whenever o_empty is low.
module sync_fifo #(
    parameter int W     = 24,
    parameter int DEPTH = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_wr_en,
    input  logic [W-1:0] i_wr_data,
    input  logic         i_rd_en,
    output logic [W-1:0] o_rd_data,
    output logic         o_full,
    output logic         o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic         w_wr;
    logic         w_rd;

    // A write into a full FIFO is only legal when the head is leaving in the same cycle.
    assign w_wr = i_wr_en & (~o_full | i_rd_en);
    assign w_rd = i_rd_en & ~o_empty;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/glyph_row_capture.sv
// Rebuilds glyph-row bytes from the active pixel stream, tags them with their text
// position and queues them for a valid/ready consumer, one frame per arming.
module glyph_row_capture
    import vga_pkg::*;
(
    input  logic                   clock_in,
    input  logic                   reset_n_in,
    input  logic [WIDTH_BITS-1:0]  pixel_x_in,
    input  logic [HEIGHT_BITS-1:0] pixel_y_in,
    input  logic [PIXEL_BITS-1:0]  pixel_in,
    input  logic                   video_on_in,
    input  logic                   v_sync_in,
    input  logic                   enable_in,
    output logic                   glyph_valid_out,
    input  logic                   glyph_ready_in,
    output logic [6:0]             glyph_col_out,
    output logic [4:0]             glyph_row_out,
    output logic [3:0]             glyph_line_out,
    output logic [0:7]             glyph_bits_out,
    output logic [15:0]            glyph_count_out,
    output logic                   overflow_out,
    output logic                   frame_done_out
);

    // Handshake: a record transfers on any rising edge where glyph_valid_out and
    // glyph_ready_in are both high; fields hold steady while valid waits on ready.

    state_t                  r_state;
    state_t                  w_next_state;
    logic                    r_vs_prev;
    logic [0:7]              r_shift;
    logic [0:7]              w_shift_next;
    logic [WIDTH_BITS-1:0]   r_last_x;
    logic                    r_last_sampled;
    logic                    r_grp_ok;
    logic [15:0]             r_count;
    logic                    r_overflow;
    logic                    w_vs_fall;
    logic                    w_start;
    logic                    w_sample;
    logic                    w_contig;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_accept;
    logic                    w_drop;
    logic                    w_full;
    logic                    w_empty;
    logic [2:0]              w_slot;
    glyph_rec_t              w_rec;
    glyph_rec_t              w_out_rec;
    logic [REC_W-1:0]        w_rd_data;

    assign w_vs_fall = r_vs_prev & ~v_sync_in;
    assign w_slot    = pixel_x_in[2:0];
    assign w_sample  = (r_state == CAPTURE) && video_on_in
                       && (pixel_x_in < WIDTH_BITS'(WIDTH))
                       && (pixel_y_in < HEIGHT_BITS'(HEIGHT));
    // A group is only trusted if every pixel arrived on back-to-back sampled cycles.
    assign w_contig  = r_last_sampled && r_grp_ok && (pixel_x_in == r_last_x + WIDTH_BITS'(1));
    assign w_push    = w_sample && (w_slot == 3'd7) && w_contig;
    assign w_pop     = ~w_empty & glyph_ready_in;
    assign w_accept  = w_push & (~w_full | w_pop);
    assign w_drop    = w_push & w_full & ~w_pop;
    assign w_start   = (r_state == WAIT_FRAME) && (w_next_state == CAPTURE);

    always_comb begin
        w_shift_next         = (w_slot == 3'd0) ? 8'h00 : r_shift;
        w_shift_next[w_slot] = |pixel_in;
    end

    assign w_rec = {pixel_x_in[9:3], pixel_y_in[8:4], pixel_y_in[3:0], w_shift_next};

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:       if (enable_in) w_next_state = WAIT_FRAME;
            WAIT_FRAME: begin
                if (!enable_in)     w_next_state = IDLE;
                else if (w_vs_fall) w_next_state = CAPTURE;
            end
            CAPTURE:    if (w_vs_fall) w_next_state = DRAIN;
            DRAIN:      if (w_empty) w_next_state = enable_in ? WAIT_FRAME : IDLE;
            default:    w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_vs_prev      <= 1'b1;
            r_shift        <= '0;
            r_last_x       <= '0;
            r_last_sampled <= 1'b0;
            r_grp_ok       <= 1'b0;
            r_count        <= '0;
            r_overflow     <= 1'b0;
        end else begin
            r_vs_prev      <= v_sync_in;
            r_last_sampled <= w_sample;
            if (w_sample) begin
                r_shift  <= w_shift_next;
                r_last_x <= pixel_x_in;
                r_grp_ok <= (w_slot == 3'd0) ? 1'b1 : w_contig;
            end
            if (w_start) begin
                r_count    <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (w_accept && (r_count != 16'hFFFF)) r_count <= r_count + 16'd1;
                if (w_drop) r_overflow <= 1'b1;
            end
        end
    end

    sync_fifo #(
        .W     (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (clock_in),
        .i_rst_n   (reset_n_in),
        .i_wr_en   (w_accept),
        .i_wr_data (w_rec),
        .i_rd_en   (w_pop),
        .o_rd_data (w_rd_data),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    assign w_out_rec       = w_empty ? '0 : glyph_rec_t'(w_rd_data);
    assign glyph_valid_out = ~w_empty;
    assign glyph_col_out   = w_out_rec.col;
    assign glyph_row_out   = w_out_rec.row;
    assign glyph_line_out  = w_out_rec.line;
    assign glyph_bits_out  = w_out_rec.bits;
    assign glyph_count_out = r_count;
    assign overflow_out    = r_overflow;
    assign frame_done_out  = (r_state == DRAIN) && w_empty;

endmodule

// File: tb/tb_glyph_row_capture.sv
// Randomised and directed bench for glyph_row_capture with a span-level reference model.
module tb_glyph_row_capture;
    import vga_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  px;
    logic [9:0]  py;
    logic [11:0] pix;
    logic        von;
    logic        vs;
    logic        en;
    logic        ready;
    logic        valid;
    logic [6:0]  col;
    logic [4:0]  row;
    logic [3:0]  line;
    logic [0:7]  bits;
    logic [15:0] count;
    logic        ovf;
    logic        done;

    int          n_checks   = 0;
    int          n_fails    = 0;
    int          n_done     = 0;
    int          pat_mode   = 0;
    logic        rand_ready = 1'b0;
    logic [23:0] exp_q[$];
    logic [23:0] got_q[$];
    logic [11:0] pat [0:1023];

    // clock / reset
    always #5 clk = ~clk;

    glyph_row_capture dut (
        .clock_in        (clk),
        .reset_n_in      (rst_n),
        .pixel_x_in      (px),
        .pixel_y_in      (py),
        .pixel_in        (pix),
        .video_on_in     (von),
        .v_sync_in       (vs),
        .enable_in       (en),
        .glyph_valid_out (valid),
        .glyph_ready_in  (ready),
        .glyph_col_out   (col),
        .glyph_row_out   (row),
        .glyph_line_out  (line),
        .glyph_bits_out  (bits),
        .glyph_count_out (count),
        .overflow_out    (ovf),
        .frame_done_out  (done)
    );

    // records leaving the DUT and end-of-frame pulses
    always @(negedge clk) begin
        if (rst_n === 1'b1 && valid === 1'b1 && ready === 1'b1) got_q.push_back({col, row, line, bits});
        if (done === 1'b1) n_done++;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) ready = ready ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    function automatic logic [11:0] pix_val(input int x, input int y);
        if (pat_mode == 1) return (((x ^ y) & 1) != 0) ? 12'hABC : 12'h000;
        return pat[x];
    endfunction

    task automatic rand_pat();
        for (int i = 0; i < 1024; i++) pat[i] = ($urandom_range(0, 1) == 1) ? 12'($urandom) : 12'h000;
    endtask

    task automatic idle(input int n);
        von = 1'b0;
        repeat (n) tick();
    endtask

    // n consecutive pixels from x0; gap_at>=0 inserts one blank cycle before pixel gap_at
    task automatic drive_span(input int y, input int x0, input int n, input int gap_at);
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) begin
                von = 1'b0;
                tick();
            end
            px  = 10'(x0 + i);
            py  = 10'(y);
            pix = pix_val(x0 + i, y);
            von = 1'b1;
            tick();
        end
    endtask

    // reference: every 8-aligned, fully covered, unbroken, in-range group yields one record
    task automatic model_span(input int y, input int x0, input int n, input int gap_at, output int nrec);
        logic [7:0] b;
        nrec = 0;
        for (int s = ((x0 + 7) / 8) * 8; s + 7 <= x0 + n - 1; s += 8) begin
            if (s + 7 < WIDTH && y < HEIGHT && !(gap_at > 0 && s < x0 + gap_at && x0 + gap_at <= s + 7)) begin
                for (int k = 0; k < 8; k++) b[7-k] = (pix_val(s + k, y) != 12'h000);
                exp_q.push_back({7'(s / 8), 5'(y / 16), 4'(y % 16), b});
                nrec++;
            end
        end
    endtask

    task automatic start_capture();
        en = 1'b1;
        vs = 1'b1;
        tick();
        tick();
        vs = 1'b0;
        tick();
        vs = 1'b1;
        tick();
    endtask

    task automatic end_frame(output int pulses);
        int d0;
        d0         = n_done;
        rand_ready = 1'b0;
        ready      = 1'b1;
        von        = 1'b0;
        vs         = 1'b0;
        tick();
        vs = 1'b1;
        for (int i = 0; i < 200 && n_done == d0; i++) tick();
        tick();
        tick();
        pulses = n_done - d0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; px = '0; py = '0; pix = '0; von = 1'b0; vs = 1'b1; en = 1'b0; ready = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({valid, col, row, line, bits, count, ovf, done} !== '0) begin
            n_fails++;
            $display("FAIL reset_outputs: got %h expected 0", {valid, col, row, line, bits, count, ovf, done});
        end
        rst_n = 1'b1;
        ready = 1'b1;
        tick();
        rand_pat();
        vs = 1'b0; tick(); vs = 1'b1; tick();
        drive_span(2, 0, 16, -1);
        idle(3);
        en = 1'b1;
        drive_span(2, 16, 16, -1);
        idle(3);
        n_checks++;
        if (got_q.size() != 0 || count !== 16'd0 || valid !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_not_armed: got %0d records count %0d, expected 0 and 0", got_q.size(), count);
        end
        ready = 1'b0;
        start_capture();
        drive_span(5, 0, 24, -1);
        idle(2);
        n_checks++;
        if (valid !== 1'b1 || count !== 16'd3) begin
            n_fails++;
            $display("FAIL reset_prefill: got valid %b count %0d expected 1 and 3", valid, count);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({valid, col, row, line, bits, count, ovf, done} !== '0) begin
            n_fails++;
            $display("FAIL reset_midstream: got %h expected 0", {valid, col, row, line, bits, count, ovf, done});
        end
        tick();
        rst_n = 1'b1;
        en    = 1'b0;
        ready = 1'b1;
        idle(6);
        n_checks++;
        if (got_q.size() != 0 || valid !== 1'b0 || count !== 16'd0) begin
            n_fails++;
            $display("FAIL reset_discard: got %0d records valid %b, expected 0 and 0", got_q.size(), valid);
        end
    endtask

    task automatic test_single_group();
        int p;
        got_q.delete();
        pat_mode = 0;
        for (int i = 0; i < 1024; i++) pat[i] = 12'h000;
        pat[0] = 12'hFFF;
        pat[7] = 12'hFFF;
        ready  = 1'b1;
        start_capture();
        drive_span(0, 0, 7, -1);
        n_checks++;
        if (valid !== 1'b0) begin
            n_fails++;
            $display("FAIL single_early_valid: got %b expected 0", valid);
        end
        drive_span(0, 7, 1, -1);
        n_checks++;
        if (valid !== 1'b1 || {col, row, line, bits} !== {7'd0, 5'd0, 4'd0, 8'b1000_0001}) begin
            n_fails++;
            $display("FAIL single_record: got valid %b rec %h expected 1 %h", valid, {col, row, line, bits}, {7'd0, 5'd0, 4'd0, 8'b1000_0001});
        end
        idle(3);
        n_checks++;
        if (count !== 16'd1 || got_q.size() != 1) begin
            n_fails++;
            $display("FAIL single_count: got count %0d popped %0d expected 1 and 1", count, got_q.size());
        end
        end_frame(p);
        n_checks++;
        if (p != 1) begin
            n_fails++;
            $display("FAIL single_done: got %0d pulses expected 1", p);
        end
    endtask

    task automatic test_position_mapping();
        int p;
        got_q.delete();
        for (int i = 632; i < 640; i++) pat[i] = 12'h001;
        ready = 1'b0;
        start_capture();
        drive_span(479, 632, 8, -1);
        n_checks++;
        if ({col, row, line, bits} !== {7'd79, 5'd29, 4'd15, 8'hFF}) begin
            n_fails++;
            $display("FAIL map_last_cell: got %h expected %h", {col, row, line, bits}, {7'd79, 5'd29, 4'd15, 8'hFF});
        end
        ready = 1'b1;
        drive_span(479, 640, 8, -1);
        idle(2);
        drive_span(480, 0, 8, -1);
        idle(3);
        n_checks++;
        if (count !== 16'd1 || got_q.size() != 1) begin
            n_fails++;
            $display("FAIL map_out_of_range: got count %0d popped %0d expected 1 and 1", count, got_q.size());
        end
        end_frame(p);
    endtask

    task automatic test_partial();
        int p, nr, tot;
        got_q.delete();
        exp_q.delete();
        rand_pat();
        ready = 1'b1;
        tot   = 0;
        start_capture();
        drive_span(3, 0, 4, -1);
        idle(3);
        drive_span(3, 4, 4, -1);
        idle(2);
        n_checks++;
        if (count !== 16'd0) begin
            n_fails++;
            $display("FAIL partial_dropped: got count %0d expected 0", count);
        end
        drive_span(3, 0, 16, 4);  model_span(3, 0, 16, 4, nr);  tot += nr;
        idle(2);
        drive_span(3, 16, 4, -1); model_span(3, 16, 4, -1, nr); tot += nr;
        drive_span(3, 28, 12, -1); model_span(3, 28, 12, -1, nr); tot += nr;
        idle(4);
        n_checks++;
        if (count !== 16'(tot) || tot != 2) begin
            n_fails++;
            $display("FAIL partial_count: got %0d expected %0d", count, tot);
        end
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fails++;
            $display("FAIL partial_qsize: got %0d records expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fails++;
                $display("FAIL partial_rec%0d: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
        end_frame(p);
    endtask

    task automatic test_backpressure();
        int p, nr;
        got_q.delete();
        exp_q.delete();
        rand_pat();
        ready = 1'b0;
        start_capture();
        drive_span(7, 0, 72, -1);
        model_span(7, 0, 72, -1, nr);
        while (exp_q.size() > FIFO_DEPTH) void'(exp_q.pop_back());
        idle(2);
        n_checks++;
        if (count !== 16'd8 || ovf !== 1'b1 || valid !== 1'b1) begin
            n_fails++;
            $display("FAIL bp_full: got count %0d ovf %b valid %b expected 8 1 1", count, ovf, valid);
        end
        ready = 1'b1;
        idle(12);
        n_checks++;
        if (got_q.size() != 8 || ovf !== 1'b1) begin
            n_fails++;
            $display("FAIL bp_drain: got %0d records ovf %b expected 8 and 1", got_q.size(), ovf);
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fails++;
                $display("FAIL bp_rec%0d: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
        end_frame(p);
    endtask

    task automatic test_full_push_pop();
        int p, nr;
        got_q.delete();
        exp_q.delete();
        rand_pat();
        ready = 1'b0;
        start_capture();
        model_span(9, 0, 72, -1, nr);
        drive_span(9, 0, 71, -1);
        ready = 1'b1;
        drive_span(9, 71, 1, -1);
        idle(12);
        n_checks++;
        if (count !== 16'd9 || ovf !== 1'b0) begin
            n_fails++;
            $display("FAIL pushpop_full: got count %0d ovf %b expected 9 and 0", count, ovf);
        end
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fails++;
            $display("FAIL pushpop_qsize: got %0d records expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fails++;
                $display("FAIL pushpop_rec%0d: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
        end_frame(p);
    endtask

    task automatic test_random();
        int p, nr, tot, y, x0, n, gap;
        got_q.delete();
        exp_q.delete();
        rand_pat();
        tot = 0;
        ready = 1'b1;
        start_capture();
        rand_ready = 1'b1;
        for (int it = 0; it < 30; it++) begin
            y   = $urandom_range(0, 479);
            x0  = $urandom_range(0, 620);
            n   = $urandom_range(2, 40);
            gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, n - 1) : -1;
            drive_span(y, x0, n, gap);
            model_span(y, x0, n, gap, nr);
            tot += nr;
            idle($urandom_range(1, 3));
        end
        rand_ready = 1'b0;
        ready = 1'b1;
        idle(10);
        n_checks++;
        if (count !== 16'(tot) || ovf !== 1'b0) begin
            n_fails++;
            $display("FAIL random_count: got count %0d ovf %b expected %0d and 0", count, ovf, tot);
        end
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fails++;
            $display("FAIL random_qsize: got %0d records expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fails++;
                $display("FAIL random_rec%0d: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
        end_frame(p);
    endtask

    task automatic test_full_frame();
        int p, nr, tot, d0;
        got_q.delete();
        exp_q.delete();
        pat_mode = 1;
        tot      = 0;
        ready    = 1'b1;
        start_capture();
        d0 = n_done;
        for (int y = 0; y < 32; y++) begin
            drive_span(y, 0, WIDTH, -1);
            model_span(y, 0, WIDTH, -1, nr);
            tot += nr;
            von = 1'b0;
            for (int k = 0; k < 16; k++) begin
                px = 10'(WIDTH + k);
                tick();
            end
        end
        n_checks++;
        if (n_done != d0) begin
            n_fails++;
            $display("FAIL frame_early_done: got %0d pulses expected 0", n_done - d0);
        end
        end_frame(p);
        n_checks++;
        if (p != 1 || count !== 16'(tot) || tot != 2560 || ovf !== 1'b0) begin
            n_fails++;
            $display("FAIL frame_summary: got pulses %0d count %0d ovf %b expected 1 %0d 0", p, count, ovf, tot);
        end
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fails++;
            $display("FAIL frame_qsize: got %0d records expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fails++;
                $display("FAIL frame_rec%0d: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
        idle(20);
        n_checks++;
        if (count !== 16'd2560) begin
            n_fails++;
            $display("FAIL frame_hold: got count %0d expected 2560", count);
        end
        vs = 1'b0; tick(); vs = 1'b1; tick(); tick();
        n_checks++;
        if (count !== 16'd0) begin
            n_fails++;
            $display("FAIL frame_restart_clear: got count %0d expected 0", count);
        end
        en = 1'b0;
        end_frame(p);
    endtask

    initial begin
        test_reset();
        test_single_group();
        test_position_mapping();
        test_partial();
        test_backpressure();
        test_full_push_pop();
        test_random();
        test_full_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
